second_tick_gen: RTL and testbench

//  Timebase and seconds stage feeding minute_counter_ver2: divides clk down to a
//  1 Hz tick and counts seconds 0..59. On the 59->0 wrap it drives the carry that

---
 rtl/second_tick_gen.sv | 179 +++++++++++++++++
 tb/tb_second_tick_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/second_tick_gen.sv
// Seconds stage: divides clk to a 1 Hz tick, counts 0..59, and emits a one-cycle
// carry on the RUN-mode 59->0 wrap. SET mode adjusts the count via debounced buttons.

// Button front end: 2-FF synchroniser, stable-level debounce and a one-cycle press
// strobe on the accepted high->low transition. The synchroniser resets to "released".
module second_tick_btn #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_vld;
    logic          r_deb;
    logic          r_arm;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_vld   <= 2'b00;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
        end
    end

    // r_arm stays low until a genuine released level is seen after reset, so a
    // button held through reset release is absorbed silently rather than counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb   <= 1'b1;
            r_arm   <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic; the default clear
            // below is overridden by a later assignment in the same block.
            r_press <= 1'b0;
            if (r_vld[1] && r_sync2 && r_deb) begin
                r_arm <= 1'b1;
            end
            if (r_sync2 != r_deb) begin
                if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_deb   <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_deb & r_arm;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

module second_tick_gen #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       add,
    input  logic       deduct,
    output logic       tick,
    output logic       second,
    output logic [5:0] second1
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_mode_s1;
    logic          r_mode_s2;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_carry;
    logic [5:0]    r_sec;
    logic          w_add_ev;
    logic          w_ded_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    second_tick_btn #(.DEB_CYCLES(DEB_CYCLES)) u_add_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (add),
        .o_press (w_add_ev)
    );

    second_tick_btn #(.DEB_CYCLES(DEB_CYCLES)) u_ded_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (deduct),
        .o_press (w_ded_ev)
    );

    // tick, the seconds update and the wrap carry all register on the same edge,
    // so the carry is aligned with second1 reading 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_sec   <= 6'd0;
        end else begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (r_mode_s2) begin
                        r_state <= ST_SET;
                        r_presc <= '0;
                    end else if (r_presc == PW'(CLK_HZ - 1)) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        if (r_sec == 6'd59) begin
                            r_sec   <= 6'd0;
                            r_carry <= 1'b1;
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_SET: begin
                    r_presc <= '0;
                    if (!r_mode_s2) begin
                        r_state <= ST_RUN;
                    end
                    // add wins when both strobes land in the same cycle
                    if (w_add_ev) begin
                        r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                    end else if (w_ded_ev) begin
                        r_sec <= (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign tick    = r_tick;
    assign second  = r_carry;
    assign second1 = r_sec;

endmodule

// File: tb/tb_second_tick_gen.sv
// Directed bench for second_tick_gen with CLK_HZ=10 and DEB_CYCLES=4; inputs
// change and outputs are sampled 1 time unit after each rising clock edge.
module tb_second_tick_gen;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       add;
    logic       deduct;
    logic       tick;
    logic       second;
    logic [5:0] second1;

    int n_total = 0;
    int n_bad   = 0;

    second_tick_gen #(.CLK_HZ(10), .DEB_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .add     (add),
        .deduct  (deduct),
        .tick    (tick),
        .second  (second),
        .second1 (second1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle in SET: tick and carry must stay low every cycle.
    task automatic idle_set(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("set_tick", 32'(tick), 0);
            check("set_carry", 32'(second), 0);
        end
    endtask

    task automatic press(input bit do_add, input bit do_ded);
        if (do_add) add = 1'b0;
        if (do_ded) deduct = 1'b0;
        idle_set(10);
        add    = 1'b1;
        deduct = 1'b1;
        idle_set(8);
    endtask

    initial begin
        reset  = 1'b0;
        mode   = 1'b0;
        add    = 1'b1;
        deduct = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick", 32'(tick), 0);
        check("rst_carry", 32'(second), 0);
        check("rst_sec", 32'(second1), 0);
        reset = 1'b1;

        // 1: free run for a full minute
        for (int c = 1; c <= 600; c++) begin
            step();
            check("run_tick", 32'(tick), (c % 10 == 0) ? 1 : 0);
            check("run_sec", 32'(second1), (c / 10) % 60);
            check("run_carry", 32'(second), (c == 600) ? 1 : 0);
        end

        // enter SET: two sync cycles still in RUN, no tick possible yet
        mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("to_set_tick", 32'(tick), 0);
        end
        check("to_set_sec", 32'(second1), 0);

        // 3: bouncy add (3 low, 1 high) then a solid press -> exactly one +1
        add = 1'b0;
        idle_set(3);
        add = 1'b1;
        idle_set(1);
        add = 1'b0;
        idle_set(2);
        check("bounce_none", 32'(second1), 0);
        idle_set(10);
        add = 1'b1;
        idle_set(8);
        check("bounce_one", 32'(second1), 1);
        press(1'b0, 1'b1);
        check("ded_to0", 32'(second1), 0);
        press(1'b0, 1'b1);
        check("ded_wrap59", 32'(second1), 59);

        // 4: simultaneous add and deduct -> add only (59 wraps to 0, no carry)
        press(1'b1, 1'b1);
        check("both_add", 32'(second1), 0);

        // preload 58
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("preload58", 32'(second1), 58);

        // 2: back to RUN; RUN entered on cycle 3, ticks on 13 and 23
        mode = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            check("wrap_tick", 32'(tick), (c == 13 || c == 23) ? 1 : 0);
            check("wrap_carry", 32'(second), (c == 23) ? 1 : 0);
            check("wrap_sec", 32'(second1), (c < 13) ? 58 : (c < 23) ? 59 : 0);
        end

        // 5: presc reaches 7, go to SET, return; next tick 10 cycles after RUN entry
        for (int c = 26; c <= 28; c++) begin
            step();
            check("pre5_tick", 32'(tick), 0);
        end
        mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            check("mid_tick", 32'(tick), 0);
        end
        idle_set(6);
        check("mid_sec_kept", 32'(second1), 0);
        mode = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            step();
            check("restart_tick", 32'(tick), (c == 13) ? 1 : 0);
            check("restart_sec", 32'(second1), (c < 13) ? 0 : 1);
            check("restart_carry", 32'(second), 0);
        end

        // 6: run to 42 (add pressed in RUN is ignored), then reset mid-count
        for (int c = 1; c <= 415; c++) begin
            if (c == 395) add = 1'b0;
            step();
            check("pre_rst_sec", 32'(second1), 1 + c / 10);
        end
        #2;
        reset = 1'b0;
        #1;
        check("async_sec", 32'(second1), 0);
        check("async_tick", 32'(tick), 0);
        check("async_carry", 32'(second), 0);
        mode = 1'b1;
        step();
        step();
        reset = 1'b1;
        idle_set(20);
        check("held_no_ev", 32'(second1), 0);
        add = 1'b1;
        idle_set(8);
        check("release_no_ev", 32'(second1), 0);
        add = 1'b0;
        idle_set(10);
        check("repress_ev", 32'(second1), 1);
        add = 1'b1;
        idle_set(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
